bit_stream_tx: RTL and testbench
================================

# bit_stream_tx

Transmit-side baseband source for the bit-synchronisation chain. It produces a differentially encoded NRZ sample stream at a programmable bit rate, from either an internal PN9 generator or an external bit supplier. Each bit boundary that changes level carries a single-cycle zero-crossing sample. The 6-bit signed output feeds the receiver's bit synchroniser directly, in place of a fixed test-tone source, and serves as the transmitter for over-the-air/loopback tests of that synchroniser.

## Interface
- CLK_PER_BIT, 32: clk cycles per bit (32 MHz / 32 = 1 Mbit/s); legal range 4..1023.
- DW, 6: output sample width, two's complement.
- AMP, 31: output magnitude for a full-level bit; must satisfy 1 <= AMP <= 2^(DW-1)-1.

Ports:
- clk  in  1  system clock, 32 MHz.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable.
- src_sel  in  1  bit source: 0 = internal PN9, 1 = external din.
- din  in  1  external source bit; sampled only in the boundary cycle.
- din_req  out  1  one-cycle request for the next external bit.
- bit_strobe  out  1  one-cycle pulse marking the first cycle of each new bit.
- bit_out  out  1  current differentially encoded bit.
- dataout  out  DW  signed baseband sample.

## Operation
- Bit counter cnt runs 0..CLK_PER_BIT-1 while en=1. The boundary cycle is the cycle in which cnt==CLK_PER_BIT-1; cnt wraps to 0 on the following edge.
- While en=0:
  - cnt, din_req and bit_strobe are forced to 0, and active is cleared.
  - dataout is forced to 0.
  - The LFSR state, the differential state and bit_out hold their values.
- After en rises, the first boundary occurs CLK_PER_BIT cycles later. Until then dataout=0.
- Source bit b:
  - src_sel=0: b = lfsr[8]. The LFSR advances only on a boundary edge: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]} (x^9+x^5+1). Seed is 9'h1FF.
  - src_sel=1: b = din, sampled on the boundary edge.
  - src_sel is sampled only on boundary edges. Changing it mid-bit has no effect on the current bit.
- Differential encoding on each boundary edge: d_new = d_old XOR b; bit_out <= d_new.
- Mapping: level(1) = +AMP, level(0) = -AMP.
- dataout on each boundary edge:
  - If active=1 and d_new != d_old, dataout <= 0 for exactly one cycle, then level(d_new) on the next edge.
  - Otherwise dataout <= level(d_new) immediately.
  - On the first boundary after enable (active=0), dataout goes directly to level, with no zero cycle. active is then set.
- dataout holds the level until the next boundary.
- Reset values: cnt=0, lfsr=9'h1FF, d=0, active=0, bit_out=0, bit_strobe=0, din_req=0, dataout=0.
- Asserting reset mid-bit clears all state immediately, asynchronously. The stream restarts from the PN seed once rst deasserts and en=1.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- din_req=1 in the cycle where cnt==CLK_PER_BIT-2, and only when en=1 and src_sel=1. The supplier must present din valid in the following (boundary) cycle. din has zero-cycle hold tolerance only at that edge; there is no backpressure.
- bit_strobe=1 in the cycle immediately after the boundary edge (cnt==0). It is asserted together with the updated bit_out.
- Latency:
  - LFSR bit to bit_out: 1 clk after the boundary edge.
  - On a transition: dataout reads 0 at cnt==0 and level(d_new) from cnt==1 through cnt==CLK_PER_BIT-1.
  - With no transition: dataout reads level(d_new) from cnt==0.
- Bit period is exactly CLK_PER_BIT cycles, with no drift. en falling mid-bit aborts the bit with no strobe. When en is reasserted, counting restarts from cnt=0.

## Test plan
- PN, default parameters, en=1 from reset release:
  - The first 9 PN bits are all 1, so bit_out alternates 1,0,1,0,…
  - bit_strobe pulses every 32 clks.
  - dataout sequence: first bit +31 from cnt==0; from the second bit onward, 0 at cnt==0 then ±31 for 31 cycles.
- PN periodicity: run 511×32 clks after the first strobe; the lfsr value and the bit_out sequence repeat with period 511 bits.
- External source, src_sel=1, din constant 0: no transitions, dataout constant -31 after the first strobe. din_req pulses at cnt==30 every 32 clks.
- External source with din alternating 1,1,0 per request: bit_out follows the running XOR. dataout shows a zero-crossing cycle exactly on bits where b=1.
- Enable toggling: drop en at cnt==10, hold it low 50 clks, then raise it.
  - dataout=0 and no strobes while en is low.
  - The first strobe arrives 32 clks after re-enable.
  - The LFSR continues from where it stopped.
- Asynchronous reset asserted mid-bit (cnt==17):
  - All outputs read 0 within the same cycle.
  - After release, the output matches the first scenario from the start.

Source files
------------

// File: rtl/bit_stream_tx.sv
// bit_stream_tx: differential NRZ baseband source with programmable bit rate.
// Bits come from an internal PN9 generator or from an external supplier.
// Every level-changing bit boundary after the first carries one zero sample.
module bit_stream_tx #(
    parameter int CLK_PER_BIT = 32,
    parameter int DW          = 6,
    parameter int AMP         = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 src_sel,
    input  logic                 din,
    output logic                 din_req,
    output logic                 bit_strobe,
    output logic                 bit_out,
    output logic signed [DW-1:0] dataout
);

    localparam int                    CW       = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]         CNT_LAST = CW'(CLK_PER_BIT - 1);
    // din_req is registered, so it is launched one cycle ahead of cnt==CLK_PER_BIT-2
    localparam logic [CW-1:0]         CNT_REQ  = CW'(CLK_PER_BIT - 3);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [8:0]            PN_SEED  = 9'h1FF;
    localparam logic signed [DW-1:0]  LVL_HI   = DW'(AMP);
    localparam logic signed [DW-1:0]  LVL_LO   = DW'(-AMP);
    localparam logic signed [DW-1:0]  LVL_ZERO = DW'(0);

    logic [CW-1:0] cnt_r;
    logic [8:0]    lfsr_r;
    logic          d_r;
    logic          active_r;
    logic          zero_pend_r;
    logic          din_req_r;
    logic          bit_strobe_r;
    logic signed [DW-1:0] dataout_r;

    logic          boundary_s;
    logic          b_s;
    logic          d_new_s;
    logic [8:0]    lfsr_next_s;

    // Map a differential bit onto the signed output level.
    function automatic logic signed [DW-1:0] level(input logic d);
        logic signed [DW-1:0] v;
        if (d) begin
            v = LVL_HI;
        end else begin
            v = LVL_LO;
        end
        return v;
    endfunction

    // Boundary detection, source bit selection, differential encode and PN step.
    always_comb begin
        boundary_s  = 1'b0;
        b_s         = 1'b0;
        d_new_s     = d_r;
        lfsr_next_s = lfsr_r;
        if (en && (cnt_r == CNT_LAST)) begin
            boundary_s = 1'b1;
        end else begin
            boundary_s = 1'b0;
        end
        if (src_sel) begin
            b_s         = din;
            lfsr_next_s = lfsr_r;
        end else begin
            b_s         = lfsr_r[8];
            lfsr_next_s = {lfsr_r[7:0], lfsr_r[8] ^ lfsr_r[4]};
        end
        d_new_s = d_r ^ b_s;
    end

    // Bit timing, PN/differential state and registered output samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= '0;
            lfsr_r       <= PN_SEED;
            d_r          <= 1'b0;
            active_r     <= 1'b0;
            zero_pend_r  <= 1'b0;
            din_req_r    <= 1'b0;
            bit_strobe_r <= 1'b0;
            dataout_r    <= LVL_ZERO;
        end else if (!en) begin
            // Idle: timing and output cleared, PN and differential state kept.
            cnt_r        <= '0;
            active_r     <= 1'b0;
            zero_pend_r  <= 1'b0;
            din_req_r    <= 1'b0;
            bit_strobe_r <= 1'b0;
            dataout_r    <= LVL_ZERO;
        end else begin
            din_req_r    <= src_sel && (cnt_r == CNT_REQ);
            bit_strobe_r <= boundary_s;
            if (boundary_s) begin
                cnt_r    <= '0;
                lfsr_r   <= lfsr_next_s;
                d_r      <= d_new_s;
                active_r <= 1'b1;
                if (active_r && b_s) begin
                    // Level change: one zero-crossing sample before the new level.
                    dataout_r   <= LVL_ZERO;
                    zero_pend_r <= 1'b1;
                end else begin
                    dataout_r   <= level(d_new_s);
                    zero_pend_r <= 1'b0;
                end
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
                if (zero_pend_r) begin
                    dataout_r   <= level(d_r);
                    zero_pend_r <= 1'b0;
                end else begin
                    dataout_r   <= dataout_r;
                    zero_pend_r <= 1'b0;
                end
            end
        end
    end

    assign din_req    = din_req_r;
    assign bit_strobe = bit_strobe_r;
    assign bit_out    = d_r;
    assign dataout    = dataout_r;

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed self-checking bench for bit_stream_tx at default parameters.
module tb_bit_stream_tx;

    logic              clk;
    logic              rst;
    logic              en;
    logic              src_sel;
    logic              din;
    logic              din_req;
    logic              bit_strobe;
    logic              bit_out;
    logic signed [5:0] dataout;

    int total = 0;
    int bad   = 0;

    // PN9 reference sequence s[n+9] = s[n] ^ s[n+4], seed all ones
    bit s [0:1199];
    bit rec [0:1100];
    logic [1:20] tab;          // hand-derived bit_out for bits 1..20 after seed
    int pn_idx;
    int bitn;
    bit m_d;
    bit first_flag;

    bit_stream_tx #(.CLK_PER_BIT(32), .DW(6), .AMP(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .src_sel    (src_sel),
        .din        (din),
        .din_req    (din_req),
        .bit_strobe (bit_strobe),
        .bit_out    (bit_out),
        .dataout    (dataout)
    );

    // 32 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lvl(input bit d);
        return d ? 31 : -31;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full bit period: 31 mid-bit samples of the previous bit, then the new bit's first cycle
    task automatic do_bit(input bit ext, input bit dval);
        logic signed [31:0] lvl_prev;
        bit b;
        bit trans;
        lvl_prev = first_flag ? 0 : lvl(m_d);
        for (int j = 1; j <= 31; j++) begin
            @(negedge clk);
            chk("strobe_mid", bit_strobe, 0);
            chk("din_req", din_req, (ext && j == 30) ? 1 : 0);
            chk("data_mid", dataout, lvl_prev);
            chk("bit_hold", bit_out, m_d);
            if (ext && j == 30) din = dval;
        end
        @(negedge clk);
        if (ext) begin
            b = dval;
        end else begin
            b = s[pn_idx];
            pn_idx++;
        end
        trans = b && !first_flag;
        m_d   = m_d ^ b;
        bitn++;
        chk("strobe_edge", bit_strobe, 1);
        chk("din_req_edge", din_req, 0);
        chk("bit_new", bit_out, m_d);
        chk("data_cnt0", dataout, trans ? 0 : lvl(m_d));
        rec[bitn] = bit_out;
        if (!ext && bitn <= 20) chk("pn_hand", bit_out, tab[bitn]);
        din = ~dval;
        first_flag = 1'b0;
    endtask

    initial begin
        tab = 20'b1010_1010_1111_1101_0110;
        for (int n = 0; n < 9; n++) s[n] = 1'b1;
        for (int n = 9; n < 1200; n++) s[n] = s[n-9] ^ s[n-5];

        rst = 1'b0; en = 1'b1; src_sel = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", dataout, 0);
        chk("rst_bit", bit_out, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_req", din_req, 0);

        // PN from reset, long enough to see two full periods
        pn_idx = 0; bitn = 0; m_d = 1'b0; first_flag = 1'b1;
        rst = 1'b1;
        for (int n = 0; n < 1031; n++) do_bit(1'b0, 1'b0);
        for (int n = 512; n <= 1022; n++) chk("pn_period", rec[n], rec[n-511]);

        // Enable toggling: drop at cnt==10, low for 50 clocks
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("pre_drop", dataout, lvl(m_d));
        end
        en = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            chk("off_data", dataout, 0);
            chk("off_strobe", bit_strobe, 0);
            chk("off_bit", bit_out, m_d);
            chk("off_req", din_req, 0);
        end
        en = 1'b1;
        first_flag = 1'b1;
        do_bit(1'b0, 1'b0);
        do_bit(1'b0, 1'b0);

        // Asynchronous reset at cnt==17
        repeat (17) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_data", dataout, 0);
        chk("arst_bit", bit_out, 0);
        chk("arst_strobe", bit_strobe, 0);
        chk("arst_req", din_req, 0);
        repeat (3) @(negedge clk);
        pn_idx = 0; bitn = 0; m_d = 1'b0; first_flag = 1'b1;
        rst = 1'b1;
        for (int n = 0; n < 20; n++) do_bit(1'b0, 1'b0);

        // External source, constant 0
        @(negedge clk);
        rst = 1'b0; src_sel = 1'b1; din = 1'b1;
        repeat (2) @(negedge clk);
        bitn = 0; m_d = 1'b0; first_flag = 1'b1;
        rst = 1'b1;
        for (int n = 0; n < 3; n++) do_bit(1'b1, 1'b0);

        // External source, pattern 1,1,0
        for (int n = 0; n < 2; n++) begin
            do_bit(1'b1, 1'b1);
            do_bit(1'b1, 1'b1);
            do_bit(1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
